// File: rtl/spike_detector.sv
// spike_detector: threshold spike detector for the high-pass filtered
// sample stream. Tracks the largest-magnitude sample of each
// above-threshold run and emits one event per run with that peak's amplitude
// and sample timestamp. A refractory window follows every event.
module spike_detector #(
    parameter int TS_WIDTH    = 32,
    parameter int PEAK_MAX    = 8,
    parameter int REFRACT_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [15:0]         in_data,
    input  logic [14:0]         thresh,
    output logic                spike_valid,
    output logic [15:0]         spike_peak,
    output logic [TS_WIDTH-1:0] spike_time,
    output logic [15:0]         spike_count,
    output logic                busy
);

    // Counter widths sized so the largest loaded value fits.
    localparam int PN_W = (PEAK_MAX < 2) ? 1 : $clog2(PEAK_MAX + 1);
    localparam int RF_W = (REFRACT_LEN < 2) ? 1 : $clog2(REFRACT_LEN + 1);
    localparam logic [PN_W-1:0] PN_MAX  = PN_W'(PEAK_MAX);
    localparam logic [RF_W-1:0] RF_INIT = RF_W'(REFRACT_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEAK    = 2'd1,
        REFRACT = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [TS_WIDTH-1:0]   ts_reg, ts_next;
    logic [15:0]           pk_val_reg, pk_val_next;
    logic [14:0]           pk_mag_reg, pk_mag_next;
    logic [TS_WIDTH-1:0]   pk_time_reg, pk_time_next;
    logic [PN_W-1:0]       pk_n_reg, pk_n_next;
    logic [RF_W-1:0]       rf_n_reg, rf_n_next;
    logic                  spike_valid_reg, spike_valid_next;
    logic [15:0]           spike_peak_reg, spike_peak_next;
    logic [TS_WIDTH-1:0]   spike_time_reg, spike_time_next;
    logic [15:0]           spike_count_reg, spike_count_next;
    logic                  busy_reg, busy_next;

    logic [15:0] abs16;
    logic [14:0] mag;
    logic        above;
    logic        emit;

    // Magnitude saturated to 15 bits so -32768 maps to 32767.
    always_comb begin
        abs16 = in_data[15] ? (~in_data + 16'd1) : in_data;
        mag   = abs16[15] ? 15'h7FFF : abs16[14:0];
        above = (mag > thresh);
    end

    // Next-state logic: peak tracking, termination, refractory countdown.
    always_comb begin
        state_next       = state_reg;
        ts_next          = ts_reg;
        pk_val_next      = pk_val_reg;
        pk_mag_next      = pk_mag_reg;
        pk_time_next     = pk_time_reg;
        pk_n_next        = pk_n_reg;
        rf_n_next        = rf_n_reg;
        spike_valid_next = 1'b0;
        spike_peak_next  = spike_peak_reg;
        spike_time_next  = spike_time_reg;
        spike_count_next = spike_count_reg;
        emit             = 1'b0;

        if (in_valid) begin
            ts_next = ts_reg + TS_WIDTH'(1);
            case (state_reg)
                IDLE: begin
                    if (above) begin
                        pk_val_next  = in_data;
                        pk_mag_next  = mag;
                        pk_time_next = ts_reg;
                        pk_n_next    = PN_W'(1);
                        if (PEAK_MAX == 1) emit = 1'b1;
                        else               state_next = PEAK;
                    end
                end
                PEAK: begin
                    if (!above) begin
                        // Terminating sample is not folded into the peak.
                        emit = 1'b1;
                    end else begin
                        // Strict compare: ties keep the earlier sample.
                        if (mag > pk_mag_reg) begin
                            pk_val_next  = in_data;
                            pk_mag_next  = mag;
                            pk_time_next = ts_reg;
                        end
                        pk_n_next = pk_n_reg + PN_W'(1);
                        if (pk_n_next == PN_MAX) emit = 1'b1;
                    end
                end
                REFRACT: begin
                    rf_n_next = rf_n_reg - RF_W'(1);
                    if (rf_n_reg == RF_W'(1)) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase

            if (emit) begin
                spike_valid_next = 1'b1;
                spike_peak_next  = pk_val_next;
                spike_time_next  = pk_time_next;
                spike_count_next = spike_count_reg + 16'd1;
                if (REFRACT_LEN == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next = REFRACT;
                    rf_n_next  = RF_INIT;
                end
            end
        end

        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ts_reg          <= '0;
            pk_val_reg      <= '0;
            pk_mag_reg      <= '0;
            pk_time_reg     <= '0;
            pk_n_reg        <= '0;
            rf_n_reg        <= '0;
            spike_valid_reg <= 1'b0;
            spike_peak_reg  <= '0;
            spike_time_reg  <= '0;
            spike_count_reg <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ts_reg          <= ts_next;
            pk_val_reg      <= pk_val_next;
            pk_mag_reg      <= pk_mag_next;
            pk_time_reg     <= pk_time_next;
            pk_n_reg        <= pk_n_next;
            rf_n_reg        <= rf_n_next;
            spike_valid_reg <= spike_valid_next;
            spike_peak_reg  <= spike_peak_next;
            spike_time_reg  <= spike_time_next;
            spike_count_reg <= spike_count_next;
            busy_reg        <= busy_next;
        end
    end

    assign spike_valid = spike_valid_reg;
    assign spike_peak  = spike_peak_reg;
    assign spike_time  = spike_time_reg;
    assign spike_count = spike_count_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_spike_detector.sv
// tb_spike_detector: table of samples with expected strobe/busy per accepted
// cycle; expected events go through a scoreboard queue. A second instance with
// a 4-bit timestamp covers counter wrap.
module tb_spike_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [14:0] thresh = '0;

    logic        spike_valid, busy;
    logic [15:0] spike_peak, spike_count;
    logic [31:0] spike_time;

    logic        w_valid, w_busy;
    logic [15:0] w_peak, w_count;
    logic [3:0]  w_time;

    spike_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .thresh(thresh), .spike_valid(spike_valid), .spike_peak(spike_peak),
        .spike_time(spike_time), .spike_count(spike_count), .busy(busy)
    );

    spike_detector #(.TS_WIDTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .thresh(thresh), .spike_valid(w_valid), .spike_peak(w_peak),
        .spike_time(w_time), .spike_count(w_count), .busy(w_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        bit          v;
        logic [15:0] d;
        logic [14:0] th;
        bit          ev;
        logic [15:0] pk;
        logic [31:0] tm;
        logic [15:0] cnt;
        bit          bsy;
    } vec_t;

    typedef struct {
        logic [15:0] pk;
        logic [31:0] tm;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cur_th = 1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rs, input bit v, input int d, input bit ev,
                       input int pk, input int tm, input int cnt, input bit bsy);
        vec_t x;
        x.rs  = rs;
        x.v   = v;
        x.d   = d[15:0];
        x.th  = cur_th[14:0];
        x.ev  = ev;
        x.pk  = pk[15:0];
        x.tm  = tm;
        x.cnt = cnt[15:0];
        x.bsy = bsy;
        tbl.push_back(x);
    endtask

    task automatic s(input int d, input bit bsy);
        add(1'b0, 1'b1, d, 1'b0, 0, 0, 0, bsy);
    endtask

    task automatic g(input int d, input bit bsy);
        add(1'b0, 1'b0, d, 1'b0, 0, 0, 0, bsy);
    endtask

    task automatic e(input int d, input int pk, input int tm, input int cnt, input bit bsy);
        add(1'b0, 1'b1, d, 1'b1, pk, tm, cnt, bsy);
    endtask

    task automatic r();
        add(1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ex;
        bit   found;

        // Basic event then refractory window and retrigger.
        cur_th = 1000;
        r();
        s(0, 0); s(0, 0); s(-1500, 1); s(-3000, 1); s(-2000, 1);
        e(500, -3000, 3, 1, 1);
        s(-5000, 1); s(-5000, 1); s(-5000, 1); s(-5000, 0);
        s(-5000, 1);
        e(0, -5000, 10, 2, 1);
        repeat (3) s(0, 1);
        s(0, 0);

        // PEAK_MAX cut with a tie, refractory, then new trigger.
        r();
        s(2000, 1); s(2000, 1); s(2500, 1); s(-2500, 1);
        s(2000, 1); s(2000, 1); s(2000, 1);
        e(2000, 2500, 2, 1, 1);
        s(2000, 1); s(2000, 1); s(2000, 1); s(2000, 0);
        s(2000, 1); s(2000, 1);
        e(0, 2000, 12, 2, 1);
        repeat (3) s(0, 1);
        s(0, 0);

        // Saturation of -32768.
        r();
        cur_th = 32766;
        s(-32768, 1);
        e(0, -32768, 0, 1, 1);
        repeat (3) s(0, 1);
        s(0, 0);
        cur_th = 32767;
        s(-32768, 0); s(0, 0);

        // Valid gaps across an event, then reset while in PEAK.
        r();
        cur_th = 1000;
        s(0, 0); g(-9000, 0); s(0, 0); g(-9000, 0);
        s(-1500, 1); g(-9000, 1); s(-3000, 1); g(-9000, 1);
        s(-2000, 1); g(-9000, 1);
        e(500, -3000, 3, 1, 1);
        g(-9000, 1);
        repeat (3) s(0, 1);
        s(0, 0);
        s(5000, 1); s(6000, 1);
        r();
        s(-4000, 1);
        e(0, -4000, 0, 1, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rs) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                $display("vec %0d: reset", i);
                chk($sformatf("v%0d_rst_valid", i), spike_valid, 0);
                chk($sformatf("v%0d_rst_peak", i), spike_peak, 0);
                chk($sformatf("v%0d_rst_time", i), spike_time, 0);
                chk($sformatf("v%0d_rst_count", i), spike_count, 0);
                chk($sformatf("v%0d_rst_busy", i), busy, 0);
                chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
                sb.delete();
                rst = 1'b0;
            end else begin
                in_valid = tbl[i].v;
                in_data  = tbl[i].d;
                thresh   = tbl[i].th;
                if (tbl[i].ev) begin
                    ex.pk  = tbl[i].pk;
                    ex.tm  = tbl[i].tm;
                    ex.cnt = tbl[i].cnt;
                    sb.push_back(ex);
                end
                @(posedge clk);
                #1;
                $display("vec %0d: v=%0d d=%0d th=%0d sv=%0d peak=%0d time=%0d count=%0d busy=%0d",
                         i, in_valid, $signed(in_data), thresh, spike_valid,
                         $signed(spike_peak), spike_time, spike_count, busy);
                chk($sformatf("v%0d_valid", i), spike_valid, tbl[i].ev);
                chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
                if (spike_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL v%0d_extra_event: got event expected none", i);
                    end else begin
                        ex = sb.pop_front();
                        chk($sformatf("v%0d_peak", i), spike_peak, ex.pk);
                        chk($sformatf("v%0d_time", i), spike_time, ex.tm);
                        chk($sformatf("v%0d_count", i), spike_count, ex.cnt);
                    end
                end else if (sb.size() != 0) begin
                    void'(sb.pop_front());
                end
            end
        end

        // Timestamp wrap on the 4-bit instance: 16 quiet samples, then a spike.
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        thresh = 15'd1000;
        in_data = 16'd0;
        repeat (16) @(posedge clk);
        #1;
        in_data = 16'd2000;
        @(posedge clk);
        #1;
        in_data = 16'd0;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge clk);
            #1;
            if (w_valid) found = 1'b1;
        end
        $display("wrap: seen=%0d peak=%0d time=%0d wide_time=%0d",
                 found, $signed(w_peak), w_time, spike_time);
        chk("wrap_seen", found, 1);
        if (found) begin
            chk("wrap_time", w_time, 0);
            chk("wrap_peak", w_peak, 2000);
            chk("wrap_count", w_count, 1);
            chk("wide_time", spike_time, 16);
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
